// File: rtl/bw_seq_multiplier_if.sv
// Handshake/bus interface for bw_seq_multiplier.
// The operand-mode signal tc exists only when BW_MODE_EN is defined.
interface bw_seq_multiplier_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
`ifdef BW_MODE_EN
    logic             tc;
`endif
    logic [2*N-1:0]   s;
    logic             busy;
    logic             done;

`ifdef BW_MODE_EN
    modport master (output start, output a, output b, output tc,
                    input s, input busy, input done);
    modport slave  (input start, input a, input b, input tc,
                    output s, output busy, output done);
`else
    modport master (output start, output a, output b,
                    input s, input busy, input done);
    modport slave  (input start, input a, input b,
                    output s, output busy, output done);
`endif
endinterface

// File: rtl/bw_seq_multiplier.sv
// Sequential Baugh-Wooley multiplier: one partial-product row per clock,
// N clocks from accept to done, 2N-bit product held until the next done.
// Optional feature macro: BW_MODE_EN adds input tc to select two's-complement
// (tc=1) or unsigned (tc=0) operands; without it the unit is always signed.
module bw_seq_multiplier #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    bw_seq_multiplier_if.slave bus
);
    localparam int              CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST_ROW = CW'(N - 1);
    localparam logic [2*N-1:0]  ONE_W    = {{(2*N-1){1'b0}}, 1'b1};
    // Baugh-Wooley correction: 2^N + 2^(2N-1), added once with row 0.
    localparam logic [2*N-1:0]  BW_CORR  = (ONE_W << N) | (ONE_W << (2*N-1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_nxt;
    logic [N-1:0]     a_r, a_nxt;
    logic [N-1:0]     b_r, b_nxt;
    logic [2*N-1:0]   acc_r, acc_nxt;
    logic [CW-1:0]    row_r, row_nxt;
    logic [2*N-1:0]   s_r, s_nxt;
    logic             busy_r, busy_nxt;
    logic             done_r, done_nxt;
    logic             signed_mode_s;

    logic [N-1:0]     row_bits_s;
    logic [2*N-1:0]   row_shift_s;
    logic [2*N-1:0]   corr_s;
    logic [2*N-1:0]   acc_sum_s;

`ifdef BW_MODE_EN
    logic             mode_r, mode_nxt;
    assign signed_mode_s = mode_r;
`else
    assign signed_mode_s = 1'b1;
`endif

    // One partial-product row: in signed mode the bits where exactly one of
    // row/column is the sign position are complemented (NAND instead of AND).
    function automatic logic [N-1:0] pp_row(
        input logic [N-1:0]  mcand,
        input logic          mbit,
        input logic [CW-1:0] row,
        input logic          sgn
    );
        logic [N-1:0] bits;
        logic         row_msb;
        row_msb = (row == LAST_ROW);
        for (int j = 0; j < N; j++) begin
            if (sgn && (row_msb != (j == N - 1))) begin
                bits[j] = ~(mcand[j] & mbit);
            end else begin
                bits[j] = mcand[j] & mbit;
            end
        end
        return bits;
    endfunction

    // Datapath for the current row: shifted row plus one-time correction.
    always_comb begin
        row_bits_s  = pp_row(a_r, b_r[row_r], row_r, signed_mode_s);
        row_shift_s = {{N{1'b0}}, row_bits_s} << row_r;
        if (signed_mode_s && (row_r == {CW{1'b0}})) begin
            corr_s = BW_CORR;
        end else begin
            corr_s = {(2*N){1'b0}};
        end
        acc_sum_s = acc_r + row_shift_s + corr_s;
    end

    // Next-state and next-register values; every target defaulted first.
    always_comb begin
        state_nxt = state_r;
        a_nxt     = a_r;
        b_nxt     = b_r;
        acc_nxt   = acc_r;
        row_nxt   = row_r;
        s_nxt     = s_r;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
`ifdef BW_MODE_EN
        mode_nxt  = mode_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_nxt     = bus.a;
                    b_nxt     = bus.b;
`ifdef BW_MODE_EN
                    mode_nxt  = bus.tc;
`endif
                    acc_nxt   = {(2*N){1'b0}};
                    row_nxt   = {CW{1'b0}};
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                acc_nxt  = acc_sum_s;
                busy_nxt = 1'b1;
                if (row_r == LAST_ROW) begin
                    s_nxt     = acc_sum_s;
                    row_nxt   = {CW{1'b0}};
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    row_nxt   = row_r + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Operand, accumulator, product and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= {N{1'b0}};
            b_r    <= {N{1'b0}};
            acc_r  <= {(2*N){1'b0}};
            row_r  <= {CW{1'b0}};
            s_r    <= {(2*N){1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef BW_MODE_EN
            mode_r <= 1'b0;
`endif
        end else begin
            a_r    <= a_nxt;
            b_r    <= b_nxt;
            acc_r  <= acc_nxt;
            row_r  <= row_nxt;
            s_r    <= s_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
`ifdef BW_MODE_EN
            mode_r <= mode_nxt;
`endif
        end
    end

    assign bus.s    = s_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Self-checking bench for bw_seq_multiplier: directed N=8 cases plus random
// traffic on N=4, 8 and 16 instances, checked through per-instance scoreboards.
module tb_bw_seq_multiplier;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [63:0] sb4[$];
    logic [63:0] sb8[$];
    logic [63:0] sb16[$];

    bw_seq_multiplier_if #(.N(4))  if4 ();
    bw_seq_multiplier_if #(.N(8))  if8 ();
    bw_seq_multiplier_if #(.N(16)) if16 ();

    bw_seq_multiplier #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    bw_seq_multiplier #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    bw_seq_multiplier #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference product from integer arithmetic, truncated to 2n bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] av, input logic [31:0] bv,
                                             input int n, input logic tcm);
        longint      sa;
        longint      sb;
        logic [63:0] mask;
        sa = longint'(av);
        sb = longint'(bv);
        if (tcm && av[n-1]) sa = sa - (longint'(1) << n);
        if (tcm && bv[n-1]) sb = sb - (longint'(1) << n);
        mask = (64'd1 << (2 * n)) - 64'd1;
        return 64'(sa * sb) & mask;
    endfunction

    // Scoreboard monitors: every done pulse pops and compares one product.
    always @(negedge clk) begin
        if (!rst && if4.done) begin
            if (sb4.size() == 0) check_eq("n4_unexpected_done", 64'(if4.done), 64'd0);
            else check_eq("n4_product", 64'(if4.s), sb4.pop_front());
        end
        if (!rst && if8.done) begin
            if (sb8.size() == 0) check_eq("n8_unexpected_done", 64'(if8.done), 64'd0);
            else check_eq("n8_product", 64'(if8.s), sb8.pop_front());
        end
        if (!rst && if16.done) begin
            if (sb16.size() == 0) check_eq("n16_unexpected_done", 64'(if16.done), 64'd0);
            else check_eq("n16_product", 64'(if16.s), sb16.pop_front());
        end
    end

    // Drive one N=8 operation and step past the accepting edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic [63:0] exp);
        if8.a     = av;
        if8.b     = bv;
        if8.start = 1'b1;
        sb8.push_back(exp);
        @(posedge clk); #1;
        if8.start = 1'b0;
        check_eq("busy_after_accept", 64'(if8.busy), 64'd1);
    endtask

    // Count edges until done is seen (bounded).
    task automatic wait_done8(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!if8.done && cnt < 40);
    endtask

    task automatic rand_ops4();
        int issued = 0;
        int guard  = 0;
        logic tcm;
        while ((issued < 1000 || sb4.size() != 0) && guard < 40000) begin
            @(posedge clk); #1;
            guard++;
            if (!if4.busy && issued < 1000 && $urandom_range(0, 3) != 0) begin
                tcm = 1'b1;
`ifdef BW_MODE_EN
                tcm = 1'($urandom_range(0, 1));
                if4.tc = tcm;
`endif
                if4.a = 4'($urandom);
                if4.b = 4'($urandom);
                if4.start = 1'b1;
                sb4.push_back(ref_prod(32'(if4.a), 32'(if4.b), 4, tcm));
                issued++;
            end else begin
                if4.start = if4.busy & 1'($urandom_range(0, 1));
                if4.a = 4'($urandom);
                if4.b = 4'($urandom);
`ifdef BW_MODE_EN
                if4.tc = 1'($urandom_range(0, 1));
`endif
            end
        end
        if4.start = 1'b0;
        check_eq("n4_random_complete", 64'(guard < 40000), 64'd1);
    endtask

    task automatic rand_ops8();
        int issued = 0;
        int guard  = 0;
        logic tcm;
        while ((issued < 1000 || sb8.size() != 0) && guard < 40000) begin
            @(posedge clk); #1;
            guard++;
            if (!if8.busy && issued < 1000 && $urandom_range(0, 3) != 0) begin
                tcm = 1'b1;
`ifdef BW_MODE_EN
                tcm = 1'($urandom_range(0, 1));
                if8.tc = tcm;
`endif
                if8.a = 8'($urandom);
                if8.b = 8'($urandom);
                if8.start = 1'b1;
                sb8.push_back(ref_prod(32'(if8.a), 32'(if8.b), 8, tcm));
                issued++;
            end else begin
                if8.start = if8.busy & 1'($urandom_range(0, 1));
                if8.a = 8'($urandom);
                if8.b = 8'($urandom);
`ifdef BW_MODE_EN
                if8.tc = 1'($urandom_range(0, 1));
`endif
            end
        end
        if8.start = 1'b0;
        check_eq("n8_random_complete", 64'(guard < 40000), 64'd1);
    endtask

    task automatic rand_ops16();
        int issued = 0;
        int guard  = 0;
        logic tcm;
        while ((issued < 1000 || sb16.size() != 0) && guard < 40000) begin
            @(posedge clk); #1;
            guard++;
            if (!if16.busy && issued < 1000 && $urandom_range(0, 3) != 0) begin
                tcm = 1'b1;
`ifdef BW_MODE_EN
                tcm = 1'($urandom_range(0, 1));
                if16.tc = tcm;
`endif
                if16.a = 16'($urandom);
                if16.b = 16'($urandom);
                if16.start = 1'b1;
                sb16.push_back(ref_prod(32'(if16.a), 32'(if16.b), 16, tcm));
                issued++;
            end else begin
                if16.start = if16.busy & 1'($urandom_range(0, 1));
                if16.a = 16'($urandom);
                if16.b = 16'($urandom);
`ifdef BW_MODE_EN
                if16.tc = 1'($urandom_range(0, 1));
`endif
            end
        end
        if16.start = 1'b0;
        check_eq("n16_random_complete", 64'(guard < 40000), 64'd1);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        if4.start = 1'b0;  if4.a = 4'd0;   if4.b = 4'd0;
        if8.start = 1'b0;  if8.a = 8'd0;   if8.b = 8'd0;
        if16.start = 1'b0; if16.a = 16'd0; if16.b = 16'd0;
`ifdef BW_MODE_EN
        if4.tc = 1'b1; if8.tc = 1'b1; if16.tc = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_s", 64'(if8.s), 64'd0);
        check_eq("reset_busy", 64'(if8.busy), 64'd0);
        check_eq("reset_done", 64'(if8.done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // -128 * -128 with latency check and product hold
        issue8(8'h80, 8'h80, 64'h4000);
        wait_done8(cnt);
        check_eq("latency_80x80", 64'(cnt), 64'd8);
        repeat (3) @(posedge clk);
        #1;
        check_eq("s_held", 64'(if8.s), 64'h4000);
        check_eq("idle_busy", 64'(if8.busy), 64'd0);

        issue8(8'h80, 8'h7F, 64'hC080);
        wait_done8(cnt);
        check_eq("latency_80x7f", 64'(cnt), 64'd8);
        issue8(8'hFF, 8'h01, 64'hFFFF);
        wait_done8(cnt);
        check_eq("latency_ffx01", 64'(cnt), 64'd8);

`ifdef BW_MODE_EN
        if8.tc = 1'b0;
        issue8(8'hFF, 8'hFF, 64'hFE01);
        wait_done8(cnt);
        check_eq("latency_unsigned", 64'(cnt), 64'd8);
        if8.tc = 1'b1;
        issue8(8'hFF, 8'hFF, 64'h0001);
        wait_done8(cnt);
        check_eq("latency_signed", 64'(cnt), 64'd8);
`endif

        // Mid-run start pulse must be ignored; then back-to-back from DONE.
        issue8(8'h02, 8'h03, 64'h0006);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if8.start = 1'b1;
        if8.a = 8'h55;
        if8.b = 8'hAA;
        @(posedge clk); #1;
        if8.start = 1'b0;
        check_eq("busy_mid_run", 64'(if8.busy), 64'd1);
        wait_done8(cnt);
        check_eq("latency_ignored_start", 64'(cnt), 64'd5);
        if8.a = 8'h03;
        if8.b = 8'hFB;
        if8.start = 1'b1;
        sb8.push_back(64'hFFF1);
        @(posedge clk); #1;
        if8.start = 1'b0;
        check_eq("b2b_busy", 64'(if8.busy), 64'd1);
        check_eq("b2b_no_done", 64'(if8.done), 64'd0);
        wait_done8(cnt);
        check_eq("latency_b2b", 64'(cnt), 64'd8);
        @(posedge clk); #1;

        // Reset at E4 of a run: abandoned, no done, s cleared.
        if8.a = 8'h12;
        if8.b = 8'h34;
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrun_reset_busy", 64'(if8.busy), 64'd0);
        check_eq("midrun_reset_s", 64'(if8.s), 64'd0);
        check_eq("midrun_reset_done", 64'(if8.done), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check_eq("after_reset_s", 64'(if8.s), 64'd0);
        check_eq("after_reset_busy", 64'(if8.busy), 64'd0);

        // Reset wins over start.
        rst = 1'b1;
        if8.a = 8'h05;
        if8.b = 8'h05;
        if8.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if8.start = 1'b0;
        check_eq("rst_start_busy", 64'(if8.busy), 64'd0);
        @(posedge clk); #1;
        check_eq("rst_start_busy_later", 64'(if8.busy), 64'd0);
        check_eq("rst_start_done", 64'(if8.done), 64'd0);

        fork
            rand_ops4();
            rand_ops8();
            rand_ops16();
        join

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
